// File: rtl/banner_pkg.sv
// Shared types and constants for the end-of-game banner sequencer.
package banner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SLIDE_IN,
    HOLD,
    WAIT_KEY,
    SLIDE_OUT
  } banner_state_t;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FixedPointShift        = 6;

  localparam logic BANNER_WIN  = 1'b0;
  localparam logic BANNER_LOSE = 1'b1;

  // Counter must hold the larger of the two frame limits; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Frame counter with synchronous clear; done_o flags the frame pulse that reaches terminal_i.
module frame_tick_counter #(
  parameter int unsigned Width = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [Width-1:0] terminal_i,
  output logic             done_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the terminal_i-th tick since the last clear.
  assign done_o = tick_i && (count_q == terminal_i - 1'b1);

endmodule

// File: rtl/end_banner_controller.sv
// Win/lose banner sequencer: slide in, hold, wait for key or timeout, request restart, slide out.
module end_banner_controller
  import banner_pkg::*;
#(
  parameter int          StartX     = -64,
  parameter int          RestX      = 192,
  parameter int          BannerY    = 64,
  parameter int unsigned SlideSpeed = 256,
  parameter int unsigned HoldFrames = 90,
  parameter int unsigned KeyTimeout = 900
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               winEvent,
  input  logic               loseEvent,
  input  logic               anyKey,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               bannerSel,
  output logic               bannerVisible,
  output logic               gameFreeze,
  output logic               restartReq
);

  localparam int          XW      = 18;
  localparam int unsigned CntW    = cnt_width(HoldFrames, KeyTimeout);
  localparam logic signed [XW-1:0] StartFp = XW'(StartX * FIXED_POINT_MULTIPLIER);
  localparam logic signed [XW-1:0] RestFp  = XW'(RestX * FIXED_POINT_MULTIPLIER);
  localparam logic signed [XW-1:0] SpeedFp = XW'(SlideSpeed);

  banner_state_t         state_q, state_d;
  logic signed [XW-1:0]  x_q, x_d, x_up, x_dn;
  logic                  sel_q, sel_d;
  logic                  restart_q, restart_d;
  logic                  visible_q, freeze_q;
  logic                  cnt_clear, cnt_done;
  logic [CntW-1:0]       cnt_term;
  logic                  hold_done, key_timeout;

  assign cnt_term    = (state_q == HOLD) ? CntW'(HoldFrames) : CntW'(KeyTimeout);
  assign hold_done   = cnt_done && (state_q == HOLD);
  assign key_timeout = (KeyTimeout != 0) && cnt_done && (state_q == WAIT_KEY);

  frame_tick_counter #(
    .Width(CntW)
  ) u_frame_cnt (
    .clk_i     (clk),
    .rst_i     (resetN),
    .clear_i   (cnt_clear),
    .tick_i    (startOfFrame),
    .terminal_i(cnt_term),
    .done_o    (cnt_done)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    sel_d     = sel_q;
    restart_d = 1'b0;
    cnt_clear = 1'b0;
    x_up      = x_q + SpeedFp;
    x_dn      = x_q - SpeedFp;
    case (state_q)
      IDLE: begin
        if (winEvent || loseEvent) begin
          state_d = SLIDE_IN;
          sel_d   = loseEvent ? BANNER_LOSE : BANNER_WIN;
        end
      end
      SLIDE_IN: begin
        if (startOfFrame) begin
          if (x_up >= RestFp) begin
            x_d       = RestFp;
            state_d   = HOLD;
            cnt_clear = 1'b1;
          end else begin
            x_d = x_up;
          end
        end
      end
      HOLD: begin
        if (hold_done) begin
          state_d   = WAIT_KEY;
          cnt_clear = 1'b1;
        end
      end
      WAIT_KEY: begin
        // Key and timeout on the same cycle collapse into one restart pulse.
        if (anyKey || key_timeout) begin
          restart_d = 1'b1;
          state_d   = SLIDE_OUT;
        end
      end
      SLIDE_OUT: begin
        if (startOfFrame) begin
          if (x_dn <= StartFp) begin
            x_d     = StartFp;
            state_d = IDLE;
          end else begin
            x_d = x_dn;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q   <= IDLE;
      x_q       <= StartFp;
      sel_q     <= BANNER_WIN;
      restart_q <= 1'b0;
      visible_q <= 1'b0;
      freeze_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      sel_q     <= sel_d;
      restart_q <= restart_d;
      visible_q <= (state_d != IDLE);
      freeze_q  <= (state_d == SLIDE_IN) || (state_d == HOLD) || (state_d == WAIT_KEY);
    end
  end

  assign topLeftX      = 11'(x_q >>> FixedPointShift);
  assign topLeftY      = 11'(BannerY);
  assign bannerSel     = sel_q;
  assign bannerVisible = visible_q;
  assign gameFreeze    = freeze_q;
  assign restartReq    = restart_q;

  // A zero speed would leave the banner stuck in a slide state forever.
  slide_speed_nonzero_a : assert property (@(posedge clk) SlideSpeed != 0);

endmodule

// File: tb/tb_end_banner_controller.sv
// Bench for end_banner_controller: two builds (900-frame key timeout and no timeout) share stimulus.
module tb_end_banner_controller;

  localparam int StartX     = -64;
  localparam int RestX      = 192;
  localparam int BannerY    = 64;
  localparam int SpeedPx    = 4;
  localparam int HoldFrames = 90;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  logic sof = 1'b0, win = 1'b0, lose = 1'b0, key = 1'b0;

  logic signed [10:0] x0, y0, x1, y1;
  logic sel0, vis0, frz0, rst0;
  logic sel1, vis1, frz1, rst1;

  int n_vec = 0;
  int n_err = 0;

  end_banner_controller #(
    .KeyTimeout(900)
  ) u_dut0 (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (sof),
    .winEvent     (win),
    .loseEvent    (lose),
    .anyKey       (key),
    .topLeftX     (x0),
    .topLeftY     (y0),
    .bannerSel    (sel0),
    .bannerVisible(vis0),
    .gameFreeze   (frz0),
    .restartReq   (rst0)
  );

  end_banner_controller #(
    .KeyTimeout(0)
  ) u_dut1 (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (sof),
    .winEvent     (win),
    .loseEvent    (lose),
    .anyKey       (key),
    .topLeftX     (x1),
    .topLeftY     (y1),
    .bannerSel    (sel1),
    .bannerVisible(vis1),
    .gameFreeze   (frz1),
    .restartReq   (rst1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input integer act, input integer exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 slide in, 2 hold, 3 wait key, 4 slide out;
  // fr counts frame pulses seen since entering the phase.
  int ph[2], fr[2], msel[2], mrst[2];
  int timeout_frames[2] = '{900, 0};
  bit mvalid = 1'b0;

  function automatic int exp_x(input int p, input int f);
    int v;
    case (p)
      1: begin v = StartX + SpeedPx * f; if (v > RestX) v = RestX; end
      2, 3: v = RestX;
      4: begin v = RestX - SpeedPx * f; if (v < StartX) v = StartX; end
      default: v = StartX;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    #1;
    for (int m = 0; m < 2; m++) begin
      if (resetN) begin
        ph[m] = 0; fr[m] = 0; msel[m] = 0; mrst[m] = 0;
      end else begin
        mrst[m] = 0;
        case (ph[m])
          0: if (win || lose) begin msel[m] = lose ? 1 : 0; ph[m] = 1; fr[m] = 0; end
          1: if (sof) begin
               fr[m]++;
               if (StartX + SpeedPx * fr[m] >= RestX) begin ph[m] = 2; fr[m] = 0; end
             end
          2: if (sof) begin
               fr[m]++;
               if (fr[m] == HoldFrames) begin ph[m] = 3; fr[m] = 0; end
             end
          3: begin
               if (key || (timeout_frames[m] != 0 && sof && fr[m] + 1 == timeout_frames[m])) begin
                 mrst[m] = 1; ph[m] = 4; fr[m] = 0;
               end else if (sof) begin
                 fr[m]++;
               end
             end
          default: if (sof) begin
               fr[m]++;
               if (RestX - SpeedPx * fr[m] <= StartX) begin ph[m] = 0; fr[m] = 0; end
             end
        endcase
      end
    end
    if (resetN) mvalid = 1'b1;
    if (mvalid) begin
      chk("m0_x", x0, exp_x(ph[0], fr[0]));
      chk("m0_y", y0, BannerY);
      chk("m0_sel", sel0, msel[0]);
      chk("m0_vis", vis0, (ph[0] != 0) ? 1 : 0);
      chk("m0_frz", frz0, (ph[0] >= 1 && ph[0] <= 3) ? 1 : 0);
      chk("m0_rst", rst0, mrst[0]);
      chk("m1_x", x1, exp_x(ph[1], fr[1]));
      chk("m1_y", y1, BannerY);
      chk("m1_sel", sel1, msel[1]);
      chk("m1_vis", vis1, (ph[1] != 0) ? 1 : 0);
      chk("m1_frz", frz1, (ph[1] >= 1 && ph[1] <= 3) ? 1 : 0);
      chk("m1_rst", rst1, mrst[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      sof = 1'b1; cyc();
      sof = 1'b0; cyc();
    end
  endtask

  initial begin
    cyc(); cyc();
    resetN = 1'b0;
    chk("reset_x", x0, -64);
    chk("reset_y", y0, 64);
    chk("reset_vis", vis0, 0);
    chk("reset_frz", frz0, 0);

    win = 1'b1; cyc(); win = 1'b0;
    chk("win_sel", sel0, 0);
    chk("win_frz", frz0, 1);
    frames(63);
    chk("slide_in_63", x0, 188);
    frames(1);
    chk("slide_in_rest", x0, 192);

    frames(10);
    key = 1'b1; cyc(); key = 1'b0;
    chk("hold_key_ignored", rst0, 0);
    frames(79);
    chk("hold_still_frozen", frz0, 1);
    frames(1);
    key = 1'b1; cyc(); key = 1'b0;
    chk("key_restart", rst0, 1);
    chk("slide_out_unfreeze", frz0, 0);
    cyc();
    chk("restart_one_cycle", rst0, 0);
    frames(63);
    chk("slide_out_63", x0, -60);
    frames(1);
    chk("slide_out_end_x", x0, -64);
    chk("slide_out_end_vis", vis0, 0);

    win = 1'b1; lose = 1'b1; cyc(); win = 1'b0; lose = 1'b0;
    chk("both_sel_lose", sel0, 1);
    frames(41);
    chk("mid_slide_x", x0, 100);
    resetN = 1'b1; cyc(); resetN = 1'b0;
    chk("mid_reset_x", x0, -64);
    chk("mid_reset_vis", vis0, 0);
    chk("mid_reset_frz", frz0, 0);

    win = 1'b1; lose = 1'b1; cyc(); win = 1'b0; lose = 1'b0;
    frames(64);
    win = 1'b1; cyc(); win = 1'b0;
    chk("hold_win_ignored", sel0, 1);
    frames(90);
    frames(899);
    chk("timeout_not_yet", rst0, 0);
    sof = 1'b1; cyc(); sof = 1'b0;
    chk("timeout_pulse", rst0, 1);
    chk("no_timeout_build", rst1, 0);
    chk("no_timeout_frozen", frz1, 1);
    cyc();
    frames(64);
    key = 1'b1; cyc(); key = 1'b0;
    chk("no_timeout_key", rst1, 1);
    frames(64);

    for (int i = 0; i < 40000; i++) begin
      resetN = ($urandom_range(0, 19999) == 0);
      sof    = ($urandom_range(0, 2) == 0);
      win    = ($urandom_range(0, 299) == 0);
      lose   = ($urandom_range(0, 299) == 0);
      key    = ($urandom_range(0, 2499) == 0);
      cyc();
    end
    resetN = 1'b0; sof = 1'b0; win = 1'b0; lose = 1'b0; key = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
